// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Opcode encodings shared by the SIMD ALU pipeline and its controller.
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] ALU_AND    = 4'd0;
  localparam logic [3:0] ALU_OR     = 4'd1;
  localparam logic [3:0] ALU_ADD    = 4'd2;
  localparam logic [3:0] ALU_XOR    = 4'd3;
  localparam logic [3:0] ALU_SUB    = 4'd6;
  localparam logic [3:0] ALU_SLT    = 4'd7;
  localparam logic [3:0] ALU_ADDU   = 4'd8;
  localparam logic [3:0] ALU_ADDU_S = 4'd9;
  localparam logic [3:0] ALU_SUBU   = 4'd10;
  localparam logic [3:0] ALU_SUBU_S = 4'd11;

endpackage
`default_nettype wire

// File: rtl/simd_lane_addsub.sv
`default_nettype none
// ============================================================================
// Module   : simd_lane_addsub
// Purpose  : One unsigned SIMD lane: add/sub with optional saturation.
// Revision : 1.0  initial release
// ============================================================================
module simd_lane_addsub #(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              sub,
  input  logic              sat,
  output logic [LANE_W-1:0] y,
  output logic              sat_hit
);

  // Extra top bit is the carry (add) or borrow (sub) out of the lane.
  logic [LANE_W:0]   w_sum;
  logic [LANE_W:0]   w_dif;
  logic              w_ovf;
  logic [LANE_W-1:0] w_raw;

  assign w_sum = {1'b0, a} + {1'b0, b};
  assign w_dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_ovf   = sub ? w_dif[LANE_W] : w_sum[LANE_W];
    w_raw   = sub ? w_dif[LANE_W-1:0] : w_sum[LANE_W-1:0];
    sat_hit = sat & w_ovf;
    if (sat_hit) y = sub ? '0 : '1;
    else         y = w_raw;
  end

endmodule
`default_nettype wire

// File: rtl/alu_simd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_simd_pipe
// Purpose  : Two-stage valid/ready ALU with scalar ops, lane-wise unsigned
//            add/sub (wrap or saturate) and a sticky per-lane saturation flag.
// Revision : 1.0  initial release
// ============================================================================
module alu_simd_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LANE_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          SrcA,
  input  logic [WIDTH-1:0]          SrcB,
  input  logic [3:0]                ALUControl,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          ALUResult,
  output logic                      zero,
  output logic [WIDTH/LANE_W-1:0]   sat_flag,
  input  logic                      sat_clr
);

  localparam int LANES = WIDTH / LANE_W;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [3:0]       r_s1_op;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [LANES-1:0] r_s2_sat;
  logic [LANES-1:0] r_sat_flag;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_commit;
  logic             w_lane_sub;
  logic             w_lane_sat;
  logic [WIDTH-1:0] w_lane_y;
  logic [LANES-1:0] w_lane_hit;
  logic [WIDTH-1:0] w_result;
  logic [LANES-1:0] w_sat;
  logic             w_slt;

  assign w_s2_adv = !r_s2_valid | out_ready;
  assign w_s1_adv = !r_s1_valid | w_s2_adv;
  assign w_commit = r_s2_valid & out_ready;

  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign ALUResult = r_result;
  assign zero      = r_zero;
  assign sat_flag  = r_sat_flag;

  assign w_lane_sub = (r_s1_op == ALU_SUBU) | (r_s1_op == ALU_SUBU_S);
  assign w_lane_sat = (r_s1_op == ALU_ADDU_S) | (r_s1_op == ALU_SUBU_S);
  assign w_slt      = $signed(r_s1_a) < $signed(r_s1_b);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    simd_lane_addsub #(.LANE_W(LANE_W)) u_lane (
      .a       (r_s1_a[l*LANE_W +: LANE_W]),
      .b       (r_s1_b[l*LANE_W +: LANE_W]),
      .sub     (w_lane_sub),
      .sat     (w_lane_sat),
      .y       (w_lane_y[l*LANE_W +: LANE_W]),
      .sat_hit (w_lane_hit[l])
    );
  end

  always_comb begin
    w_result = '0;
    w_sat    = '0;
    case (r_s1_op)
      ALU_AND: w_result = r_s1_a & r_s1_b;
      ALU_OR:  w_result = r_s1_a | r_s1_b;
      ALU_ADD: w_result = r_s1_a + r_s1_b;
      ALU_XOR: w_result = r_s1_a ^ r_s1_b;
      ALU_SUB: w_result = r_s1_a - r_s1_b;
      ALU_SLT: w_result = {{(WIDTH-1){1'b0}}, w_slt};
      ALU_ADDU, ALU_ADDU_S, ALU_SUBU, ALU_SUBU_S: begin
        w_result = w_lane_y;
        w_sat    = w_lane_hit;
      end
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)         r_s1_valid <= 1'b0;
    else if (w_s1_adv) r_s1_valid <= in_valid;
  end

  // Operand registers carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (w_s1_adv && in_valid) begin
      r_s1_a  <= SrcA;
      r_s1_b  <= SrcB;
      r_s1_op <= ALUControl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_s2_sat   <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_result;
        r_zero   <= (w_result == '0);
        r_s2_sat <= w_sat;
      end
    end
  end

  // Clear applies before the committing beat's saturation bits are merged in.
  always_ff @(posedge clk) begin
    if (reset) r_sat_flag <= '0;
    else       r_sat_flag <= (sat_clr ? '0 : r_sat_flag) | (w_commit ? r_s2_sat : '0);
  end

endmodule
`default_nettype wire
